// File: rtl/xtea_seq_pkg.sv
// Shared definitions for the XTEA port sequencer: port map, control bits and FSM state codes.
package xtea_seq_pkg;

  localparam logic [7:0] PORT_KEY_ADDR = 8'h20;
  localparam logic [7:0] PORT_KEY_DATA = 8'h21;
  localparam logic [7:0] PORT_DAT_ADDR = 8'h22;
  localparam logic [7:0] PORT_DAT_DATA = 8'h23;
  localparam logic [7:0] PORT_XKEY     = 8'h30;
  localparam logic [7:0] PORT_XDATA    = 8'h31;
  localparam logic [7:0] PORT_XCTRL    = 8'h33;
  localparam logic [7:0] PORT_XSTAT    = 8'h34;
  localparam logic [7:0] PORT_XRES     = 8'h35;
  localparam logic [7:0] PORT_M3_ADDR  = 8'h40;
  localparam logic [7:0] PORT_M3_DATA  = 8'h41;

  localparam int CTRL_GO_BIT      = 0;
  localparam int CTRL_DECRYPT_BIT = 1;
  localparam int STAT_READY_BIT   = 0;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE      = 5'd0;
  localparam state_t S_KEY_ADDR  = 5'd1;
  localparam state_t S_KEY_REQ   = 5'd2;
  localparam state_t S_KEY_WAIT  = 5'd3;
  localparam state_t S_KEY_CAP   = 5'd4;
  localparam state_t S_D_ADDR    = 5'd5;
  localparam state_t S_D_REQ     = 5'd6;
  localparam state_t S_D_WAIT    = 5'd7;
  localparam state_t S_D_CAP     = 5'd8;
  localparam state_t S_SEND_KEY  = 5'd9;
  localparam state_t S_SEND_DATA = 5'd10;
  localparam state_t S_START     = 5'd11;
  localparam state_t S_POLL      = 5'd12;
  localparam state_t S_RES_SETUP = 5'd13;
  localparam state_t S_RES_CAP   = 5'd14;
  localparam state_t S_W_ADDR    = 5'd15;
  localparam state_t S_W_DATA    = 5'd16;
  localparam state_t S_FINISH    = 5'd17;

  function automatic logic [7:0] ctrl_word(input logic dec);
    logic [7:0] w;
    w = 8'h00;
    w[CTRL_GO_BIT]      = 1'b1;
    w[CTRL_DECRYPT_BIT] = dec;
    return w;
  endfunction

endpackage

// File: rtl/xtea_port_sequencer.sv
// Hardwired replacement for the PicoBlaze XTEA program: key from Mem2, blocks from Mem1
// through the XTEA peripheral, results to Mem3, all over the shared port bus.
module xtea_port_sequencer
  import xtea_seq_pkg::*;
#(
  parameter int KEY_BYTES   = 16,
  parameter int BLOCK_BYTES = 8,
  parameter int NUM_BLOCKS  = 4,
  parameter bit RELOAD_KEY  = 1'b1,
  parameter int TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  output logic [7:0] port_id,
  output logic       write_strobe,
  output logic       read_strobe,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0] KEY_LAST = 8'(KEY_BYTES - 1);
  localparam logic [7:0] BLK_LAST = 8'(BLOCK_BYTES - 1);
  localparam logic [7:0] NB_LAST  = 8'(NUM_BLOCKS - 1);
  localparam logic [7:0] BB8      = 8'(BLOCK_BYTES);
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT - 1);

  if (NUM_BLOCKS * BLOCK_BYTES > 256) begin : g_param_check
    $error("NUM_BLOCKS*BLOCK_BYTES must not exceed 256");
  end

  state_t        state, state_n;
  logic [7:0]    idx, idx_n, blk, blk_n, base, base_n;
  logic [PW-1:0] poll_cnt, poll_n;
  logic          dec_r, dec_n, err_n;
  logic [7:0]    key_buf  [KEY_BYTES];
  logic [7:0]    data_buf [BLOCK_BYTES];

  logic [7:0] port_n, out_n, send_data;
  logic       ws_n, rs_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    blk_n   = blk;
    base_n  = base;
    poll_n  = poll_cnt;
    dec_n   = dec_r;
    err_n   = error;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_KEY_ADDR;
        idx_n   = 8'd0;
        dec_n   = decrypt;
        err_n   = 1'b0;
      end
      S_KEY_ADDR: state_n = S_KEY_REQ;
      S_KEY_REQ:  state_n = S_KEY_WAIT;
      S_KEY_WAIT: state_n = S_KEY_CAP;
      S_KEY_CAP: begin
        idx_n = idx + 8'd1;
        state_n = S_KEY_ADDR;
        if (idx == KEY_LAST) begin
          state_n = S_D_ADDR;
          idx_n   = 8'd0;
          blk_n   = 8'd0;
          base_n  = 8'd0;
        end
      end
      S_D_ADDR: state_n = S_D_REQ;
      S_D_REQ:  state_n = S_D_WAIT;
      S_D_WAIT: state_n = S_D_CAP;
      S_D_CAP: begin
        idx_n   = idx + 8'd1;
        state_n = S_D_ADDR;
        if (idx == BLK_LAST) begin
          idx_n   = 8'd0;
          state_n = (RELOAD_KEY || blk == 8'd0) ? S_SEND_KEY : S_SEND_DATA;
        end
      end
      S_SEND_KEY: begin
        idx_n = idx + 8'd1;
        if (idx == KEY_LAST) begin
          state_n = S_SEND_DATA;
          idx_n   = 8'd0;
        end
      end
      S_SEND_DATA: begin
        idx_n = idx + 8'd1;
        if (idx == BLK_LAST) begin
          state_n = S_START;
          idx_n   = 8'd0;
        end
      end
      S_START: begin
        state_n = S_POLL;
        poll_n  = '0;
      end
      // A timed-out block skips its result transfer and every remaining block.
      S_POLL: begin
        if (in_port[STAT_READY_BIT]) begin
          state_n = S_RES_SETUP;
        end else if (poll_cnt == POLL_LAST) begin
          state_n = S_FINISH;
          err_n   = 1'b1;
        end else begin
          poll_n = poll_cnt + PW'(1);
        end
      end
      S_RES_SETUP: begin
        state_n = S_RES_CAP;
        idx_n   = 8'd0;
      end
      S_RES_CAP: begin
        idx_n = idx + 8'd1;
        if (idx == BLK_LAST) begin
          state_n = S_W_ADDR;
          idx_n   = 8'd0;
        end
      end
      S_W_ADDR: state_n = S_W_DATA;
      S_W_DATA: begin
        idx_n   = idx + 8'd1;
        state_n = S_W_ADDR;
        if (idx == BLK_LAST) begin
          idx_n = 8'd0;
          if (blk == NB_LAST) begin
            state_n = S_FINISH;
          end else begin
            state_n = S_D_ADDR;
            blk_n   = blk + 8'd1;
            base_n  = base + BB8;
          end
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // The last data byte is captured on the same edge a single-byte block starts sending.
  assign send_data = (state == S_D_CAP && idx == idx_n) ? in_port : data_buf[idx_n[BW-1:0]];

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    port_n = 8'h00;
    out_n  = 8'h00;
    ws_n   = 1'b0;
    rs_n   = 1'b0;
    case (state_n)
      S_KEY_ADDR:  begin port_n = PORT_KEY_ADDR; ws_n = 1'b1; out_n = idx_n; end
      S_KEY_REQ:   begin port_n = PORT_KEY_DATA; rs_n = 1'b1; end
      S_KEY_WAIT,
      S_KEY_CAP:   port_n = PORT_KEY_DATA;
      S_D_ADDR:    begin port_n = PORT_DAT_ADDR; ws_n = 1'b1; out_n = base_n + idx_n; end
      S_D_REQ:     begin port_n = PORT_DAT_DATA; rs_n = 1'b1; end
      S_D_WAIT,
      S_D_CAP:     port_n = PORT_DAT_DATA;
      S_SEND_KEY:  begin port_n = PORT_XKEY; ws_n = 1'b1; out_n = key_buf[idx_n[KW-1:0]]; end
      S_SEND_DATA: begin port_n = PORT_XDATA; ws_n = 1'b1; out_n = send_data; end
      S_START:     begin port_n = PORT_XCTRL; ws_n = 1'b1; out_n = ctrl_word(dec_n); end
      S_POLL:      port_n = PORT_XSTAT;
      S_RES_SETUP: begin port_n = PORT_XRES; rs_n = 1'b1; end
      S_RES_CAP:   begin port_n = PORT_XRES; rs_n = (idx_n != BLK_LAST); end
      S_W_ADDR:    begin port_n = PORT_M3_ADDR; ws_n = 1'b1; out_n = base_n + idx_n; end
      S_W_DATA:    begin port_n = PORT_M3_DATA; ws_n = 1'b1; out_n = data_buf[idx_n[BW-1:0]]; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= 8'd0;
      blk          <= 8'd0;
      base         <= 8'd0;
      poll_cnt     <= '0;
      dec_r        <= 1'b0;
      port_id      <= 8'h00;
      out_port     <= 8'h00;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      for (int i = 0; i < KEY_BYTES; i++)   key_buf[i]  <= 8'h00;
      for (int i = 0; i < BLOCK_BYTES; i++) data_buf[i] <= 8'h00;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      blk          <= blk_n;
      base         <= base_n;
      poll_cnt     <= poll_n;
      dec_r        <= dec_n;
      port_id      <= port_n;
      out_port     <= out_n;
      write_strobe <= ws_n;
      read_strobe  <= rs_n;
      busy         <= (state_n != S_IDLE) && (state_n != S_FINISH);
      done         <= (state_n == S_FINISH);
      error        <= err_n;
      if (state == S_KEY_CAP) key_buf[idx[KW-1:0]] <= in_port;
      if (state == S_D_CAP || state == S_RES_CAP) data_buf[idx[BW-1:0]] <= in_port;
    end
  end

endmodule

// File: tb/tb_xtea_port_sequencer.sv
// Bench for xtea_port_sequencer: two instances (key reload on/off) share stimulus, each with
// its own Mem1/Mem2/Mem3 bridge and XTEA peripheral model; Mem3 is checked against direct XTEA.
module tb_xtea_port_sequencer;

  localparam int KB = 16;
  localparam int BB = 8;
  localparam int NB = 4;
  localparam int TO = 15;
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic decrypt = 1'b0;
  logic clr = 1'b0;
  logic decrypt_run = 1'b0;
  int   ready_polls = 3;
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] xtea(input logic [127:0] key, input logic [63:0] blk, input logic dec);
    logic [31:0] k [4];
    logic [31:0] v0, v1, sum;
    for (int i = 0; i < 4; i++) k[i] = key[32*i +: 32];
    v0 = blk[31:0];
    v1 = blk[63:32];
    if (!dec) begin
      sum = 32'd0;
      for (int r = 0; r < 32; r++) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
        sum += DELTA;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
      end
    end else begin
      sum = DELTA << 5;
      for (int r = 0; r < 32; r++) begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
        sum -= DELTA;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
      end
    end
    return {v1, v0};
  endfunction

  // Each instance gets a bridge/peripheral model acting at the falling edge on that cycle's bus.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [7:0] port_id, out_port;
    logic [7:0] in_port = 8'h00;
    logic       write_strobe, read_strobe, busy, done, error;

    xtea_port_sequencer #(
      .KEY_BYTES(KB), .BLOCK_BYTES(BB), .NUM_BLOCKS(NB),
      .RELOAD_KEY(g == 0), .TIMEOUT(TO)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
      .port_id(port_id), .write_strobe(write_strobe), .read_strobe(read_strobe),
      .out_port(out_port), .in_port(in_port),
      .busy(busy), .done(done), .error(error)
    );

    int n21, n30, n31, n33, n40, n41, ctrl_bad, done_n, busy_n, done_busy;
    int kcnt, dcnt, poll_n, res_i, pend, cyc, last41_cyc, done_cyc;
    int first_key_addr = -1;
    logic [7:0]   key_a, dat_a, m3_a;
    logic [127:0] xkey;
    logic [63:0]  xdat, xres;
    logic [7:0]   mem3 [256];

    always @(negedge clk) begin
      cyc++;
      if (clr || rst) begin
        n21 = 0; n30 = 0; n31 = 0; n33 = 0; n40 = 0; n41 = 0;
        ctrl_bad = 0; done_n = 0; busy_n = 0; done_busy = 0;
        kcnt = 0; dcnt = 0; poll_n = 0; res_i = 0; pend = 0;
        last41_cyc = -1; done_cyc = -2; first_key_addr = -1;
        for (int a = 0; a < 256; a++) mem3[a] = 8'h00;
      end
      case (pend)
        1: in_port = mem2[key_a];
        2: in_port = mem1[dat_a];
        3: begin in_port = xres[8*res_i +: 8]; res_i++; end
        default: ;
      endcase
      pend = 0;
      if (write_strobe) begin
        case (port_id)
          8'h20: begin key_a = out_port; if (first_key_addr < 0) first_key_addr = int'(out_port); end
          8'h22: dat_a = out_port;
          8'h30: begin xkey[8*(kcnt % KB) +: 8] = out_port; kcnt++; n30++; end
          8'h31: begin xdat[8*(dcnt % BB) +: 8] = out_port; dcnt++; n31++; end
          8'h33: begin
            n33++;
            if (out_port !== {6'b0, decrypt_run, 1'b1}) ctrl_bad++;
            xres = xtea(xkey, xdat, out_port[1]);
            res_i = 0; poll_n = 0; dcnt = 0;
          end
          8'h40: begin m3_a = out_port; n40++; end
          8'h41: begin mem3[m3_a] = out_port; n41++; last41_cyc = cyc; end
          default: ;
        endcase
      end
      if (read_strobe) begin
        case (port_id)
          8'h21: begin n21++; pend = 1; end
          8'h23: pend = 2;
          8'h35: pend = 3;
          default: ;
        endcase
      end
      if (port_id == 8'h34 && !write_strobe && !read_strobe) begin
        poll_n++;
        in_port = {7'b0, poll_n >= ready_polls};
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_cyc = cyc;
        if (busy) done_busy++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic apply_stimulus(input logic dec);
    decrypt = dec;
    decrypt_run = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (g_inst[0].done_n >= 1 && g_inst[1].done_n >= 1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_output("done_seen", 64'(got), 64'd1);
    repeat (4) tick();
  endtask

  function automatic logic [7:0] ref_byte(input int a, input logic dec);
    logic [127:0] k;
    logic [63:0]  d, r;
    for (int i = 0; i < KB; i++) k[8*i +: 8] = mem2[i];
    for (int j = 0; j < BB; j++) d[8*j +: 8] = mem1[(a / BB) * BB + j];
    r = xtea(k, d, dec);
    return r[8*(a % BB) +: 8];
  endfunction

  // Spec cycle budget: key phase plus each block, with key resend only where the mode calls for it.
  function automatic int exp_busy(input bit reload, input int polls);
    int c = 4 * KB;
    for (int b = 0; b < NB; b++)
      c += 4*BB + ((reload || b == 0) ? KB : 0) + BB + 1 + polls + 1 + BB + 2*BB;
    return c;
  endfunction

  task automatic check_mem3(input logic dec);
    for (int a = 0; a < NB * BB; a++) begin
      check_output($sformatf("mem3_reload[%0d]", a), 64'(g_inst[0].mem3[a]), 64'(ref_byte(a, dec)));
      check_output($sformatf("mem3_once[%0d]", a), 64'(g_inst[1].mem3[a]), 64'(ref_byte(a, dec)));
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_port_id", 64'(g_inst[0].port_id), 64'h00);
    check_output("rst_out_port", 64'(g_inst[0].out_port), 64'h00);
    check_output("rst_write_strobe", 64'(g_inst[0].write_strobe), 64'd0);
    check_output("rst_read_strobe", 64'(g_inst[0].read_strobe), 64'd0);
    check_output("rst_busy", 64'(g_inst[0].busy), 64'd0);
    check_output("rst_done", 64'(g_inst[0].done), 64'd0);
    check_output("rst_error", 64'(g_inst[0].error), 64'd0);
    check_output("rst_all_once", 64'({g_inst[1].port_id, g_inst[1].out_port, g_inst[1].write_strobe,
                 g_inst[1].read_strobe, g_inst[1].busy, g_inst[1].done, g_inst[1].error}), 64'd0);
  endtask

  initial begin
    logic [127:0] tk;
    logic [63:0]  tp;
    bit hit;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'($urandom);
      mem2[i] = 8'(i);
    end
    tk = {$urandom, $urandom, $urandom, $urandom};
    tp = {$urandom, $urandom};
    check_output("model_roundtrip", xtea(tk, xtea(tk, tp, 1'b0), 1'b1), tp);

    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    $display("[TB] run 1: decrypt, ready after 3 polls");
    ready_polls = 3;
    clear_stats();
    apply_stimulus(1'b1);
    check_output("busy_after_start", 64'({g_inst[0].busy, g_inst[1].busy}), 64'b11);
    wait_done(2000);
    check_output("r1_key_reads", 64'(g_inst[0].n21), 64'(KB));
    check_output("r1_key_writes_reload", 64'(g_inst[0].n30), 64'(NB * KB));
    check_output("r1_ctrl_writes", 64'(g_inst[0].n33), 64'(NB));
    check_output("r1_ctrl_bad", 64'(g_inst[0].ctrl_bad), 64'd0);
    check_output("r1_m3_writes", 64'({g_inst[0].n40, g_inst[0].n41}), {32'(NB * BB), 32'(NB * BB)});
    check_output("r1_done_count", 64'(g_inst[0].done_n), 64'd1);
    check_output("r1_done_timing", 64'(g_inst[0].done_cyc), 64'(g_inst[0].last41_cyc + 1));
    check_output("r1_done_busy_overlap", 64'(g_inst[0].done_busy), 64'd0);
    check_output("r1_busy_cycles", 64'(g_inst[0].busy_n), 64'(exp_busy(1'b1, 3)));
    check_output("r1_error", 64'(g_inst[0].error), 64'd0);
    check_output("r1_first_key_addr", 64'(g_inst[0].first_key_addr), 64'd0);
    check_output("r1_once_key_writes", 64'(g_inst[1].n30), 64'(KB));
    check_output("r1_once_key_reads", 64'(g_inst[1].n21), 64'(KB));
    check_output("r1_once_busy_cycles", 64'(g_inst[1].busy_n), 64'(exp_busy(1'b0, 3)));
    check_output("r1_once_done_count", 64'(g_inst[1].done_n), 64'd1);
    check_mem3(1'b1);

    $display("[TB] run 2: encrypt, random key, start pulses while busy");
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'($urandom);
      mem2[i] = 8'($urandom);
    end
    clear_stats();
    apply_stimulus(1'b0);
    repeat (20) tick();
    decrypt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (150) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    decrypt = 1'b0;
    wait_done(2000);
    check_output("r2_ctrl_writes", 64'(g_inst[0].n33), 64'(NB));
    check_output("r2_ctrl_bad", 64'({g_inst[0].ctrl_bad, g_inst[1].ctrl_bad}), 64'd0);
    check_output("r2_busy_cycles", 64'(g_inst[0].busy_n), 64'(exp_busy(1'b1, 3)));
    check_output("r2_done_count", 64'(g_inst[0].done_n), 64'd1);
    check_output("r2_idle_after", 64'({g_inst[0].busy, g_inst[1].busy}), 64'd0);
    check_mem3(1'b0);

    $display("[TB] run 3: ready never asserted");
    ready_polls = 1000;
    clear_stats();
    apply_stimulus(1'b1);
    wait_done(1000);
    check_output("r3_error", 64'({g_inst[0].error, g_inst[1].error}), 64'b11);
    check_output("r3_done_count", 64'(g_inst[0].done_n), 64'd1);
    check_output("r3_m3_writes", 64'({g_inst[0].n40, g_inst[0].n41}), 64'd0);
    check_output("r3_ctrl_writes", 64'(g_inst[0].n33), 64'd1);
    check_output("r3_busy_cycles", 64'(g_inst[0].busy_n), 64'(4*KB + 4*BB + KB + BB + 1 + TO));
    repeat (5) tick();
    check_output("r3_error_sticky", 64'(g_inst[0].error), 64'd1);

    $display("[TB] run 4: reset during block 2 data send, then a fresh run");
    ready_polls = 3;
    clear_stats();
    apply_stimulus(1'b1);
    check_output("r4_error_cleared", 64'({g_inst[0].error, g_inst[1].error}), 64'd0);
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (g_inst[0].n31 >= 2 * BB + 1) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check_output("r4_reached_block2", 64'(hit), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_values();
    rst = 1'b0;
    clear_stats();
    apply_stimulus(1'b1);
    wait_done(2000);
    check_output("r4_first_key_addr", 64'(g_inst[0].first_key_addr), 64'd0);
    check_output("r4_key_reads", 64'(g_inst[0].n21), 64'(KB));
    check_output("r4_busy_cycles", 64'(g_inst[0].busy_n), 64'(exp_busy(1'b1, 3)));
    check_mem3(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
